// File: rtl/voice_alloc_pkg.sv
// Shared types and widths for the voice allocator and its voice table.
// Slot width is shared with the synth2 voice engine's c_byte0 address.
package voice_alloc_pkg;

    localparam int unsigned SLOT_W = 8;
    localparam int unsigned NOTE_W = 7;
    localparam int unsigned VEL_W  = 7;
    localparam int unsigned CHAN_W = 4;
    localparam int unsigned CNT_W  = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_ISSUE = 2'd2
    } state_t;

    typedef struct packed {
        logic              active;
        logic [NOTE_W-1:0] note;
        logic [CHAN_W-1:0] channel;
    } voice_entry_t;

    // MIDI convention: a note-on with velocity 0 is a note-off.
    function automatic logic is_key_down(input logic is_on, input logic [VEL_W-1:0] vel);
        return is_on && (vel != '0);
    endfunction

endpackage

// File: rtl/voice_table.sv
// Per-slot voice store: active flag, note and channel.
// One combinational read port for the scan, one synchronous write port.
module voice_table
    import voice_alloc_pkg::*;
#(
    parameter int unsigned NUM_VOICES = 32,
    parameter int unsigned IDX_W      = 5
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [IDX_W-1:0]   i_rd_idx,
    output voice_entry_t       o_rd_entry,
    input  logic               i_wr_en,
    input  logic [IDX_W-1:0]   i_wr_idx,
    input  voice_entry_t       i_wr_entry
);

    voice_entry_t r_tbl [NUM_VOICES];

    // Only the active flags need a reset; note/channel are don't-care when inactive.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < NUM_VOICES; i++) begin
                r_tbl[i].active <= 1'b0;
            end
        end else if (i_wr_en) begin
            r_tbl[i_wr_idx] <= i_wr_entry;
        end
    end

    assign o_rd_entry = r_tbl[i_rd_idx];

endmodule

// File: rtl/voice_alloc.sv
// Voice allocator: maps note-on/off events to voice slots with retrigger,
// free-slot search and round-robin stealing; fixed NUM_VOICES+2 latency.
module voice_alloc
    import voice_alloc_pkg::*;
#(
    parameter int unsigned NUM_VOICES = 32
) (
    input  logic              clk32,
    input  logic              rst,
    input  logic              ev_valid,
    output logic              ev_ready,
    input  logic              ev_is_on,
    input  logic [NOTE_W-1:0] ev_note,
    input  logic [VEL_W-1:0]  ev_velocity,
    input  logic [CHAN_W-1:0] ev_channel,
    output logic              note_pressed,
    output logic              note_released,
    output logic [NOTE_W-1:0] note_interface,
    output logic [VEL_W-1:0]  velocity,
    output logic [CHAN_W-1:0] channel,
    output logic [SLOT_W-1:0] slot,
    output logic              stolen,
    output logic [CNT_W-1:0]  voices_active
);

    localparam int unsigned IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    state_t r_state;
    state_t w_next_state;

    logic [IW-1:0]     r_k;
    logic [IW-1:0]     r_rr;
    logic              r_ev_on;
    logic [NOTE_W-1:0] r_ev_note;
    logic [VEL_W-1:0]  r_ev_vel;
    logic [CHAN_W-1:0] r_ev_ch;
    logic              r_match_found;
    logic [IW-1:0]     r_match_idx;
    logic              r_free_found;
    logic [IW-1:0]     r_free_idx;
    logic              r_cool;
    logic              r_pressed;
    logic              r_released;
    logic [NOTE_W-1:0] r_note_out;
    logic [VEL_W-1:0]  r_vel_out;
    logic [CHAN_W-1:0] r_ch_out;
    logic [SLOT_W-1:0] r_slot;
    logic              r_stolen;
    logic [CNT_W-1:0]  r_active_cnt;

    logic              w_accept;
    logic [IW:0]       w_scan_sum;
    logic [IW-1:0]     w_scan_idx;
    voice_entry_t      w_rd_entry;
    logic [IW-1:0]     w_target;
    logic [IW:0]       w_rr_inc;
    logic              w_wr_en;
    voice_entry_t      w_wr_entry;

    // r_cool keeps ready low for the pulse cycle that follows ISSUE.
    assign ev_ready = (r_state == ST_IDLE) && !r_cool && !rst;
    assign w_accept = ev_valid && ev_ready;

    assign w_scan_sum = {1'b0, r_rr} + {1'b0, r_k};
    assign w_scan_idx = (w_scan_sum >= (IW+1)'(NUM_VOICES)) ?
                        IW'(w_scan_sum - (IW+1)'(NUM_VOICES)) : IW'(w_scan_sum);

    assign w_target = r_match_found ? r_match_idx :
                      r_free_found  ? r_free_idx  : r_rr;
    assign w_rr_inc = {1'b0, w_target} + {{IW{1'b0}}, 1'b1};

    assign w_wr_en    = (r_state == ST_ISSUE) && (r_ev_on || r_match_found);
    assign w_wr_entry = '{active: r_ev_on, note: r_ev_note, channel: r_ev_ch};

    voice_table #(
        .NUM_VOICES (NUM_VOICES),
        .IDX_W      (IW)
    ) u_table (
        .i_clk      (clk32),
        .i_rst      (rst),
        .i_rd_idx   (w_scan_idx),
        .o_rd_entry (w_rd_entry),
        .i_wr_en    (w_wr_en),
        .i_wr_idx   (w_target),
        .i_wr_entry (w_wr_entry)
    );

    always_ff @(posedge clk32) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_next_state = ST_SCAN;
            ST_SCAN:  if (r_k == IW'(NUM_VOICES - 1)) w_next_state = ST_ISSUE;
            ST_ISSUE: w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk32) begin
        if (rst) begin
            r_k           <= '0;
            r_rr          <= '0;
            r_ev_on       <= 1'b0;
            r_ev_note     <= '0;
            r_ev_vel      <= '0;
            r_ev_ch       <= '0;
            r_match_found <= 1'b0;
            r_match_idx   <= '0;
            r_free_found  <= 1'b0;
            r_free_idx    <= '0;
            r_cool        <= 1'b0;
            r_pressed     <= 1'b0;
            r_released    <= 1'b0;
            r_note_out    <= '0;
            r_vel_out     <= '0;
            r_ch_out      <= '0;
            r_slot        <= '0;
            r_stolen      <= 1'b0;
            r_active_cnt  <= '0;
        end else begin
            r_pressed  <= 1'b0;
            r_released <= 1'b0;
            r_cool     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_ev_on       <= is_key_down(ev_is_on, ev_velocity);
                        r_ev_note     <= ev_note;
                        r_ev_vel      <= ev_velocity;
                        r_ev_ch       <= ev_channel;
                        r_k           <= '0;
                        r_match_found <= 1'b0;
                        r_free_found  <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    r_k <= r_k + 1'b1;
                    if (!r_match_found && w_rd_entry.active &&
                        w_rd_entry.note == r_ev_note && w_rd_entry.channel == r_ev_ch) begin
                        r_match_found <= 1'b1;
                        r_match_idx   <= w_scan_idx;
                    end
                    if (!r_free_found && !w_rd_entry.active) begin
                        r_free_found <= 1'b1;
                        r_free_idx   <= w_scan_idx;
                    end
                end
                ST_ISSUE: begin
                    r_cool <= 1'b1;
                    if (r_ev_on) begin
                        r_pressed  <= 1'b1;
                        r_slot     <= SLOT_W'(w_target);
                        r_stolen   <= !r_match_found && !r_free_found;
                        r_note_out <= r_ev_note;
                        r_vel_out  <= r_ev_vel;
                        r_ch_out   <= r_ev_ch;
                        r_rr       <= (w_rr_inc == (IW+1)'(NUM_VOICES)) ? '0 : IW'(w_rr_inc);
                        if (!r_match_found && r_free_found)
                            r_active_cnt <= r_active_cnt + 1'b1;
                    end else if (r_match_found) begin
                        r_released   <= 1'b1;
                        r_slot       <= SLOT_W'(r_match_idx);
                        r_stolen     <= 1'b0;
                        r_note_out   <= r_ev_note;
                        r_vel_out    <= r_ev_vel;
                        r_ch_out     <= r_ev_ch;
                        r_active_cnt <= r_active_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign note_pressed   = r_pressed;
    assign note_released  = r_released;
    assign note_interface = r_note_out;
    assign velocity       = r_vel_out;
    assign channel        = r_ch_out;
    assign slot           = r_slot;
    assign stolen         = r_stolen;
    assign voices_active  = r_active_cnt;

endmodule
